// File: rtl/adder_pkg.sv
// Shared constants, stage-count helper and per-stage record for the pipelined adder.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH = 16;
  localparam int unsigned ADDER_SLICE = 4;

  function automatic int unsigned adder_nstage(input int unsigned width,
                                               input int unsigned slice);
    return width / slice;
  endfunction

  typedef struct packed {
    logic                   valid;
    logic [ADDER_WIDTH-1:0] a_rem;
    logic [ADDER_WIDTH-1:0] b_rem;
    logic [ADDER_WIDTH-1:0] sum_done;
    logic                   carry;
  } adder_stage_t;

endpackage

// File: rtl/adder_fa.sv
// One-bit full-adder cell.
module adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple adder built from adder_fa; also exposes the carry into its MSB.
module adder_slice #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    adder_fa u_fa (
      .a_i (a[i]),
      .b_i (b[i]),
      .c_i (c[i]),
      .s_o (sum[i]),
      .c_o (c[i+1])
    );
  end

  assign cout = c[SLICE];
  assign cmsb = c[SLICE-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined adder/subtractor: one SLICE-bit slice resolved per stage, registered carry between stages.
// Optional signed-overflow output enabled by defining ADDER_PIPE_OVF_EN.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH,
  parameter int unsigned SLICE = ADDER_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NSTAGE = adder_nstage(WIDTH, SLICE);

  // Same field layout as adder_stage_t, sized for this instance's WIDTH.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum_done;
    logic             carry;
  } stage_t;

  stage_t st_q [NSTAGE];
  stage_t st_d [NSTAGE];

  logic [NSTAGE-1:0][SLICE-1:0] sl_a;
  logic [NSTAGE-1:0][SLICE-1:0] sl_b;
  logic [NSTAGE-1:0][SLICE-1:0] sl_sum;
  logic [NSTAGE-1:0]            sl_ci;
  logic [NSTAGE-1:0]            sl_co;
  logic [NSTAGE-1:0]            sl_cmsb;

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign sl_a[k]  = a[SLICE-1:0];
      assign sl_b[k]  = b_eff[SLICE-1:0];
      assign sl_ci[k] = sub | cin;
    end else begin : g_next
      assign sl_a[k]  = st_q[k-1].a_rem[k*SLICE +: SLICE];
      assign sl_b[k]  = st_q[k-1].b_rem[k*SLICE +: SLICE];
      assign sl_ci[k] = st_q[k-1].carry;
    end

    adder_slice #(.SLICE(SLICE)) u_slice (
      .a    (sl_a[k]),
      .b    (sl_b[k]),
      .cin  (sl_ci[k]),
      .sum  (sl_sum[k]),
      .cout (sl_co[k]),
      .cmsb (sl_cmsb[k])
    );
  end

  // Operand bits above the resolved slice ride along with the beat, so no output deskew is needed.
  always_comb begin
    st_d[0]                        = '{valid: in_valid, a_rem: a, b_rem: b_eff,
                                       sum_done: '0, carry: sl_co[0]};
    st_d[0].sum_done[SLICE-1:0]    = sl_sum[0];
    for (int unsigned k = 1; k < NSTAGE; k++) begin
      st_d[k]                            = st_q[k-1];
      st_d[k].sum_done[k*SLICE +: SLICE] = sl_sum[k];
      st_d[k].carry                      = sl_co[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        st_q[k] <= '0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign out_valid = st_q[NSTAGE-1].valid;
  assign sum       = st_q[NSTAGE-1].sum_done;
  assign cout      = st_q[NSTAGE-1].carry;

`ifdef ADDER_PIPE_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= sl_cmsb[NSTAGE-1] ^ sl_co[NSTAGE-1];
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_cmsb;
  assign unused_cmsb = ^sl_cmsb;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe (WIDTH=16, SLICE=4): driver pushes expectations, monitor pops on output transfers.
module tb_adder_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef ADDER_PIPE_OVF_EN
  logic        ovf;
`endif

  adder_pipe #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_PIPE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every output transfer, and watches the stall behaviour.
  logic        stall_prev = 1'b0;
  logic [15:0] held_sum;
  logic        held_cout;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_output", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("sum", {16'd0, sum}, {16'd0, e.s});
        check("cout", {31'd0, cout}, {31'd0, e.c});
`ifdef ADDER_PIPE_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
        if (e.chk_lat) check("latency", cyc - e.acc, 32'd4);
      end
    end
    if (out_valid && !out_ready) begin
      check("in_ready_stall", {31'd0, in_ready}, 32'd0);
      if (stall_prev) begin
        check("sum_held", {16'd0, sum}, {16'd0, held_sum});
        check("cout_held", {31'd0, cout}, {31'd0, held_cout});
      end
      held_sum   = sum;
      held_cout  = cout;
      stall_prev = 1'b1;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the beat is accepted.
  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vc, input logic vs,
                      input logic [15:0] es, input logic ec, input logic eo,
                      input bit push, input bit lat);
    exp_t e;
    bit   done = 1'b0;
    in_valid = 1'b1;
    a = va; b = vb; cin = vc; sub = vs;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) begin
          e.s = es; e.c = ec; e.o = eo; e.acc = cyc; e.chk_lat = lat;
          sbq.push_back(e);
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sbq.size() != 0; t++) @(posedge clk);
    check("drain_empty", sbq.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        c, s;
    logic [15:0] es;
    logic        ec, eo;
  } vec_t;

  vec_t dir[6];
  vec_t b2b[4];
  vec_t stl[6];

  initial begin
    dir[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    dir[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    dir[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    dir[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    dir[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    dir[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    b2b[0] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    b2b[1] = '{16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0};
    b2b[2] = '{16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0};
    b2b[3] = '{16'h0004, 16'h0004, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0};
    stl[0] = '{16'h0100, 16'h0011, 1'b0, 1'b0, 16'h0111, 1'b0, 1'b0};
    stl[1] = '{16'h0200, 16'h0022, 1'b0, 1'b0, 16'h0222, 1'b0, 1'b0};
    stl[2] = '{16'h0300, 16'h0033, 1'b0, 1'b0, 16'h0333, 1'b0, 1'b0};
    stl[3] = '{16'h0400, 16'h0044, 1'b0, 1'b0, 16'h0444, 1'b0, 1'b0};
    stl[4] = '{16'h0500, 16'h0055, 1'b0, 1'b0, 16'h0555, 1'b0, 1'b0};
    stl[5] = '{16'h0600, 16'h0066, 1'b0, 1'b0, 16'h0666, 1'b0, 1'b0};

    rst = 1'b1; out_ready = 1'b1;
    idle();
    #1 rst = 1'b0;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Directed vectors, one at a time with full latency check.
    for (int i = 0; i < 6; i++) begin
      send(dir[i].a, dir[i].b, dir[i].c, dir[i].s, dir[i].es, dir[i].ec, dir[i].eo, 1'b1, 1'b1);
      idle();
      drain();
    end

    // Back-to-back beats: latency 4 each implies consecutive results.
    for (int i = 0; i < 4; i++)
      send(b2b[i].a, b2b[i].b, b2b[i].c, b2b[i].s, b2b[i].es, b2b[i].ec, b2b[i].eo, 1'b1, 1'b1);
    idle();
    drain();

    // Stream of 6 with the consumer stalling for 4 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(stl[i].a, stl[i].b, stl[i].c, stl[i].s, stl[i].es, stl[i].ec, stl[i].eo, 1'b1, 1'b0);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight: nothing stale may emerge.
    for (int i = 0; i < 3; i++)
      send(b2b[i].a, b2b[i].b, b2b[i].c, b2b[i].s, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum", {16'd0, sum}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(dir[0].a, dir[0].b, dir[0].c, dir[0].s, dir[0].es, dir[0].ec, dir[0].eo, 1'b1, 1'b1);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
